// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit mid-period
// and presents the byte on a valid/ready holding register with error pulses.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rx_s_q, rx_s_d;
    logic            rx_d_q, rx_d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            fall_edge;

    assign fall_edge = rx_d_q & ~rx_s_q;

    always_comb begin
        state_d     = state_q;
        sync1_d     = rx;
        rx_s_d      = sync1_q;
        rx_d_d      = rx_s_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // A full register that is not being drained keeps its old byte.
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                    end else if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_d_q      <= rx_d_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: stimulus pushes expected
// bytes, a negedge monitor pops them on every accepted handshake.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_FREQ (16),
        .BAUD_RATE(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    int         accepted = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         valid_rise_cycle = -1;
    int         start_cycle = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever the consumer takes a byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && !valid_prev) valid_rise_cycle = cycle;
            valid_prev = rx_valid;
            if (rx_valid && rx_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no delivery", rx_data);
                end else begin
                    checkOutput("rx_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) begin
                checks++;
                errors++;
                $display("[TB] FAIL err_exclusive: got both pulses, expected at most one");
            end
        end else begin
            valid_prev = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic expect_byte);
        @(posedge clk);
        #1;
        start_cycle = cycle;
        if (expect_byte) exp_q.push_back(data);
        rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle(CPB);
            rx = data[i];
        end
        idle(CPB);
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
        idle(20);
    endtask

    int acc0;
    int fe0;
    int ov0;

    initial begin
        $display("[TB] uart_rx scoreboard bench, CPB=%0d", CPB);
        idle(3);
        checkOutput("reset_valid_in_reset", int'(rx_valid), 0);
        rst_n = 1'b1;
        idle(400);
        checkOutput("reset_valid", int'(rx_valid), 0);
        checkOutput("reset_frame_err", int'(frame_err), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        checkOutput("reset_data", int'(rx_data), 0);

        // Single byte with consumer ready; exact latency from pin edge.
        applyStimulus(8'hA5, 1'b1, 1'b1);
        checkOutput("latency_a5", valid_rise_cycle - start_cycle, 155);
        checkOutput("a5_accepted", accepted, 1);
        checkOutput("a5_no_frame_err", fe_cnt, 0);
        checkOutput("a5_valid_dropped", int'(rx_valid), 0);

        // Short glitch is rejected in START.
        acc0 = accepted;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(200);
        checkOutput("glitch_no_byte", accepted - acc0, 0);
        checkOutput("glitch_valid", int'(rx_valid), 0);
        checkOutput("glitch_no_frame_err", fe_cnt, 0);

        // Framing error, then recovery.
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("frame_err_pulse", fe_cnt, 1);
        checkOutput("frame_err_no_byte", accepted, 1);
        idle(32);
        applyStimulus(8'h81, 1'b1, 1'b1);
        checkOutput("recover_accepted", accepted, 2);
        checkOutput("recover_no_frame_err", fe_cnt, 1);

        // Overrun with consumer stalled.
        rx_ready = 1'b0;
        applyStimulus(8'h11, 1'b1, 1'b1);
        checkOutput("hold_valid", int'(rx_valid), 1);
        applyStimulus(8'h22, 1'b1, 1'b0);
        checkOutput("overrun_pulse", ov_cnt, 1);
        checkOutput("overrun_keeps_data", int'(rx_data), 8'h11);
        checkOutput("overrun_still_valid", int'(rx_valid), 1);
        rx_ready = 1'b1;
        idle(1);
        checkOutput("drain_valid", int'(rx_valid), 0);
        checkOutput("drain_accepted", accepted, 3);

        // Reset mid-frame, then a clean frame.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        @(posedge clk);
        #1;
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(4 * CPB);
        rst_n = 1'b0;
        idle(3);
        checkOutput("abort_valid", int'(rx_valid), 0);
        rst_n = 1'b1;
        idle(20);
        applyStimulus(8'h5A, 1'b1, 1'b1);
        idle(40);
        checkOutput("abort_accepted", accepted, 4);
        checkOutput("abort_no_frame_err", fe_cnt - fe0, 0);
        checkOutput("abort_no_overrun", ov_cnt - ov0, 0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
